maxpool2d_stream: RTL
=====================

Name: maxpool2d_stream

Overview:
- Streaming KxK max-pool, stride K, over IEEE-754 single-precision feature maps delivered in raster order, one pixel per cycle.
- Generalises the 2x2 combinational pool to a parametrised window size and image size, with a selectable comparison mode.
- Holds per-column partial maxima in a line buffer and emits one pooled value per window through a valid/ready handshake.
- Sits between a conv/activation stage and the next layer's input stream in the nn datapath.

Parameters:
- IMG_W, 28, pixels per row; must be a multiple of POOL.
- IMG_H, 28, rows per frame; must be a multiple of POOL.
- POOL, 2, window edge and stride (2..8).
- ABS_MODE, 1, 1 = compare by magnitude (bits[30:0]) and output the original word with its sign intact; 0 = signed IEEE ordering.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous frame abort; counters and out_valid go to 0 next cycle.
- in_data  in  32  float32 pixel.
- in_valid  in  1  pixel present.
- in_ready  out  1  pixel accepted when in_valid & in_ready.
- out_data  out  32  pooled value.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts when out_valid & out_ready.
- out_last  out  1  high with the final pooled value of a frame.
- busy  out  1  high from first accepted pixel to last output accepted.

Behaviour:
- Reset values: out_data=0, out_valid=0, out_last=0, busy=0, all counters=0. Line buffer contents are don't-care, because the first window row always overwrites them.
- Counters:
  - col (0..IMG_W-1) increments on each accepted pixel and wraps to 0 at IMG_W-1.
  - row (0..IMG_H-1) increments on each col wrap and wraps to 0 at IMG_H-1.
  - Derived values: wcol = col/POOL, kx = col%POOL, ky = row%POOL.
- Compare function gt(a,b):
  - ABS_MODE=1: unsigned a[30:0] > b[30:0].
  - ABS_MODE=0: if the signs differ, the positive value is greater. If both are positive, compare [30:0] unsigned. If both are negative, the smaller [30:0] is greater.
  - Ties (including +0 vs -0) keep the earlier pixel in raster order.
  - NaN/Inf are ordered by bit pattern only; no special handling.
- Horizontal accumulation: a running register h_max resets to the pixel at kx=0, then h_max = gt(pix,h_max) ? pix : h_max.
- Line buffer update at kx=POOL-1, with candidate = final h_max:
  - ky=0: write lbuf[wcol]=candidate.
  - 0<ky<POOL-1: write lbuf[wcol]=max(lbuf[wcol], candidate).
  - ky=POOL-1: load out_data with max(lbuf[wcol], candidate), where lbuf wins ties; set out_valid.
- Latency: out_valid rises the cycle after the bottom-right pixel of a window is accepted.
- Handshake:
  - in_ready = !out_valid | out_ready, so a stalled output blocks input.
  - out_valid clears on acceptance unless a new result loads in the same cycle.
  - Simultaneous output accept and new result load: the new value replaces the old one and out_valid stays 1.
  - out_data and out_valid are held stable while out_valid & !out_ready.
- out_last: set with the result for row=IMG_H-1, col=IMG_W-1. The counters wrap to 0 on that pixel, so the next frame can begin immediately (back-to-back frames, no bubble).
- busy:
  - Set on the first accepted pixel with row=col=0.
  - Cleared when the out_last output is accepted, unless that frame's first pixel is accepted in the same cycle.
- clear:
  - Overrides everything except Reset.
  - Clears counters, out_valid, out_last and busy.
  - A pixel presented in the clear cycle is dropped.
- Reset mid-frame: immediately returns to the reset state; the partial frame is discarded and produces no output.
- Output count per frame: (IMG_W/POOL)*(IMG_H/POOL).
- Simulation-only assertion: IMG_W%POOL==0 and IMG_H%POOL==0.

Test Plan:
- 4x4 frame (IMG_W=IMG_H=4, POOL=2, ABS_MODE=1), values 1.0..16.0 raster, out_ready=1. Required response:
  - outputs 6.0, 8.0, 14.0, 16.0;
  - each output one cycle after pixels 6, 8, 14, 16 respectively;
  - out_last only on 16.0.
- ABS_MODE=1 window {-5.0, 3.0, 2.0, 1.0} -> 0xC0A00000 (-5.0). The same window with ABS_MODE=0 -> 3.0 (0x40400000).
- Ties, ABS_MODE=1: window {+0.0, -0.0, 0, 0} -> 0x00000000. Window {-2.0, 2.0, 0, 0} -> 0xC0000000 (first wins).
- Backpressure: hold out_ready=0 for 5 cycles after the first output. Required response:
  - out_data stable;
  - in_ready=0;
  - no pixel lost;
  - the full 4x4 stream still yields 4 correct outputs.
- Back-to-back: two 4x4 frames with continuous in_valid -> 8 outputs, out_last on the 4th and 8th, busy high throughout.
- Abort:
  - Reset asserted after pixel 7 of a frame -> out_valid=0 immediately.
  - Reassert a new full frame -> exactly 4 correct outputs.
  - Repeat with clear -> same result.

Source files
------------

// File: rtl/maxpool2d_stream.sv
// rtl/maxpool2d_stream.sv - streaming KxK / stride-K max-pool over float32 raster frames
// Per-column partial maxima live in a line buffer; one pooled word is emitted per window.
module maxpool2d_stream #(
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28,
    parameter int POOL     = 2,
    parameter int ABS_MODE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy
);

    localparam int WCOLS = IMG_W / POOL;
    localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int KW    = $clog2(POOL);
    localparam int WW    = (WCOLS > 1) ? $clog2(WCOLS) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(POOL - 1);

    if ((IMG_W % POOL) != 0 || (IMG_H % POOL) != 0) begin : g_bad_geometry
        $error("maxpool2d_stream: IMG_W and IMG_H must be multiples of POOL");
    end

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [KW-1:0] kx;
    logic [KW-1:0] ky;
    logic [WW-1:0] wcol;
    logic [31:0]   h_max;
    logic [31:0]   lbuf [WCOLS];

    logic          accept;
    logic          kx_end;
    logic          ky_end;
    logic          frame_end;
    logic [31:0]   h_next;
    logic [31:0]   lb_rd;
    logic [31:0]   v_max;

    // Strict "a beats b"; equal keys return 0 so the earlier raster pixel survives.
    function automatic logic gt(input logic [31:0] a, input logic [31:0] b);
        if (ABS_MODE != 0)
            return a[30:0] > b[30:0];
        else if (a[30:0] == 31'd0 && b[30:0] == 31'd0)
            return 1'b0;
        else if (a[31] != b[31])
            return b[31];
        else if (!a[31])
            return a[30:0] > b[30:0];
        else
            return a[30:0] < b[30:0];
    endfunction

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready && !clear;
    assign kx_end    = (kx == K_LAST);
    assign ky_end    = (ky == K_LAST);
    assign frame_end = (row == ROW_LAST) && (col == COL_LAST);

    always_comb begin
        h_next = h_max;
        if (kx == '0)
            h_next = in_data;
        else if (gt(in_data, h_max))
            h_next = in_data;
    end

    // The stored value is always earlier in raster order, so it wins ties.
    assign lb_rd = lbuf[wcol];
    assign v_max = gt(h_next, lb_rd) ? h_next : lb_rd;

    always_ff @(posedge clk) begin
        if (accept && kx_end && !ky_end)
            lbuf[wcol] <= (ky == '0) ? h_next : v_max;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            kx        <= '0;
            ky        <= '0;
            wcol      <= '0;
            h_max     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else if (clear) begin
            col       <= '0;
            row       <= '0;
            kx        <= '0;
            ky        <= '0;
            wcol      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                if (out_last)
                    busy <= 1'b0;
            end

            if (accept) begin
                h_max <= h_next;

                if (col == '0 && row == '0)
                    busy <= 1'b1;

                if (kx_end && ky_end) begin
                    out_data  <= v_max;
                    out_valid <= 1'b1;
                    out_last  <= frame_end;
                end

                if (col == COL_LAST) begin
                    col  <= '0;
                    kx   <= '0;
                    wcol <= '0;
                    if (row == ROW_LAST) begin
                        row <= '0;
                        ky  <= '0;
                    end else begin
                        row <= row + RW'(1);
                        ky  <= ky_end ? '0 : ky + KW'(1);
                    end
                end else begin
                    col <= col + CW'(1);
                    if (kx_end) begin
                        kx   <= '0;
                        wcol <= wcol + WW'(1);
                    end else begin
                        kx <= kx + KW'(1);
                    end
                end
            end
        end
    end

endmodule
